sdram_burst_sequencer: RTL and testbench
========================================

# sdram_burst_sequencer

Fabric-side controller that drives the SDRAM burst start/stop handshake of the HPS/Qsys system. It consumes the HPS start PIO and the SDRAM write-response strobe, and issues a programmed number of burst-begin pulses. It measures total transfer cycles and returns the completion flag to the HPS done PIO. The measured cycle count is also exported for the hex/LED readback path.

## Interface
- NUM_BURSTS, 16 — bursts per run; legal range 1..65535.
- TIMEOUT_CYCLES, 65535 — maximum cycles allowed between a burst-begin pulse and its write response.
- CNT_W, 32 — width of cycle_count.

Ports:
- sys_ref_clk_clk  in  1  — single system clock; all logic is on its rising edge.
- sys_ref_reset_reset_n  in  1  — reset, asynchronous, active-low.
- startsignal_export  in  1  — level from the HPS start PIO; a run is armed on its rising edge.
- pushbutton_export  in  4  — KEYs, active-low, asynchronous. Only [0] is used, as abort.
- sdramstartstop_writeresponsevalid_n  in  1  — active-low; one low cycle marks one completed burst.
- sdramstartstop_beginbursttransfer  out  1  — one-cycle pulse that launches a burst.
- donesignal_export  out  1  — run-complete flag to the HPS done PIO.
- timeout_flag  out  1  — the run ended on a response timeout.
- burst_count  out  16  — number of responses received in the current or last run.
- cycle_count  out  CNT_W  — cycles spent in ISSUE+WAIT during the current or last run; saturating.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- start_q is a 1-cycle register of startsignal_export. start_rise = start & ~start_q.
- pushbutton_export[0] passes through a 2-FF synchronizer and then a falling-edge detector to produce abort.
- IDLE:
  - On start_rise: clear burst_count, cycle_count, timeout_flag and the timeout counter, then go to ISSUE.
  - Start levels that are high without a rising edge are ignored.
- ISSUE:
  - beginbursttransfer = 1 for exactly this cycle.
  - The per-burst timeout counter is reset to 0.
  - Always go to WAIT next.
- WAIT:
  - The timeout counter increments each cycle.
  - On a response (writeresponsevalid_n == 0), burst_count increments.
  - If the new burst_count == NUM_BURSTS, go to DONE; otherwise go to ISSUE.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no response, set timeout_flag and go to DONE.
- DONE:
  - donesignal_export = 1.
  - Stay until startsignal_export == 0, then go to IDLE (done clears on that transition).
- cycle_count:
  - Increments in every ISSUE and WAIT cycle.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Responses sampled in IDLE, ISSUE or DONE are ignored and not counted.
- Abort:
  - In ISSUE or WAIT: go to IDLE next cycle. done stays 0; counters freeze at their current values.
  - In IDLE or DONE: no effect.
- Simultaneous events, in priority order:
  - abort > response > timeout.
  - A response on the same cycle as the timeout threshold counts as a response, and timeout_flag stays 0.
- A start_rise while in ISSUE, WAIT or DONE is ignored.

## Timing
- Reset values: state = IDLE, every output = 0, start_q = 0, both synchronizer stages = 1 (KEY released).
- Reset asserted mid-run returns the block to IDLE immediately, with all outputs 0.
- Start to begin:
  - start goes high before edge N, so start_rise is seen at edge N.
  - beginbursttransfer is high in the cycle after edge N (1-cycle latency).
- Response to next begin:
  - A response sampled at edge M puts the block in ISSUE during cycle M+1, so begin is high in M+1.
  - The minimum burst period is therefore 2 cycles.
- Final response to done:
  - For the final response at edge M, donesignal_export is high from cycle M+1.
  - burst_count shows NUM_BURSTS in that same cycle.
- Abort latency: 3 cycles from the KEY falling edge (2 synchronizer stages plus 1 edge register) to the IDLE transition.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SDRAM_BURST_SEQ_TIMEOUT_EN defined:
  - The per-burst timeout counter and timeout_flag are implemented as described above.
- SDRAM_BURST_SEQ_TIMEOUT_EN undefined:
  - No timeout counter is built; WAIT waits for a response indefinitely.
  - timeout_flag is tied to 0; TIMEOUT_CYCLES is unused.

## Test plan
All scenarios use NUM_BURSTS=4, TIMEOUT_CYCLES=100, with the macro defined.
- Nominal run:
  - Stimulus: start rises; respond 3 cycles after each begin.
  - Required: 4 begin pulses, each exactly 1 cycle; done=1 one cycle after the 4th response; burst_count=4; cycle_count=16; timeout_flag=0.
- Start held high after done, then dropped:
  - Required: done stays 1 while start is high, and clears in the cycle after start falls.
  - A new rise then starts a fresh run with counters cleared.
- Timeout:
  - Stimulus: never respond after the 2nd begin.
  - Required: done=1 and timeout_flag=1 after 100 WAIT cycles; burst_count=1.
- Response exactly on the timeout threshold cycle:
  - Required: the response is counted, timeout_flag=0, and the run continues to the 3rd begin.
- Abort:
  - Stimulus: KEY[0] pulsed low during WAIT of burst 2.
  - Required: IDLE 3 cycles later; done=0; no further begins; counts frozen.
- Reset mid-WAIT:
  - Required: every output reads 0 immediately.
  - A stray response while in IDLE leaves burst_count=0.

Source files
------------

// File: rtl/sdram_burst_sequencer.sv
// SDRAM burst start/stop sequencer: issues NUM_BURSTS burst-begin pulses per HPS start and measures run cycles.
// Define SDRAM_BURST_SEQ_TIMEOUT_EN to build the per-burst write-response timeout and timeout_flag.
module sdram_burst_sequencer #(
    parameter int NUM_BURSTS     = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 32
) (
    input  logic             sys_ref_clk_clk,
    input  logic             sys_ref_reset_reset_n,
    input  logic             startsignal_export,
    input  logic [3:0]       pushbutton_export,
    input  logic             sdramstartstop_writeresponsevalid_n,
    output logic             sdramstartstop_beginbursttransfer,
    output logic             donesignal_export,
    output logic             timeout_flag,
    output logic [15:0]      burst_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // An out-of-range configuration never arms a run.
    localparam logic CFG_OK = (NUM_BURSTS >= 1) && (NUM_BURSTS <= 65535) &&
                              (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535);
    localparam logic [15:0]      BURST_LAST = 16'(NUM_BURSTS);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state_r;
    state_t      state_next_s;
    logic        start_q_r;
    logic        key_meta_r;
    logic        key_sync_r;
    logic        key_prev_r;
    logic        start_rise_s;
    logic        abort_s;
    logic        resp_s;
    logic        arm_s;
    logic        count_resp_s;
    logic        tmo_hit_s;
    logic        tmo_fire_s;
    logic [15:0] burst_inc_s;
    logic        unused_keys_s;

    assign unused_keys_s = ^pushbutton_export[3:1];

    assign start_rise_s = startsignal_export & ~start_q_r;
    assign abort_s      = key_prev_r & ~key_sync_r;
    assign resp_s       = ~sdramstartstop_writeresponsevalid_n;
    assign burst_inc_s  = burst_count + 16'd1;

    // Start edge register and KEY[0] synchronizer with falling-edge history.
    always_ff @(posedge sys_ref_clk_clk or negedge sys_ref_reset_reset_n) begin
        if (!sys_ref_reset_reset_n) begin
            start_q_r  <= 1'b0;
            key_meta_r <= 1'b1;
            key_sync_r <= 1'b1;
            key_prev_r <= 1'b1;
        end else begin
            start_q_r  <= startsignal_export;
            key_meta_r <= pushbutton_export[0];
            key_sync_r <= key_meta_r;
            key_prev_r <= key_sync_r;
        end
    end

    // Next-state decode; abort outranks a response, which outranks the timeout.
    always_comb begin
        state_next_s = state_r;
        arm_s        = 1'b0;
        count_resp_s = 1'b0;
        tmo_fire_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_rise_s && CFG_OK) begin
                    arm_s        = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (abort_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                if (abort_s) begin
                    state_next_s = IDLE;
                end else if (resp_s) begin
                    count_resp_s = 1'b1;
                    if (burst_inc_s == BURST_LAST) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ISSUE;
                    end
                end else if (tmo_hit_s) begin
                    tmo_fire_s   = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                if (!startsignal_export) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus pulse/flag outputs decoded from the next state so they stay registered.
    always_ff @(posedge sys_ref_clk_clk or negedge sys_ref_reset_reset_n) begin
        if (!sys_ref_reset_reset_n) begin
            state_r                           <= IDLE;
            sdramstartstop_beginbursttransfer <= 1'b0;
            donesignal_export                 <= 1'b0;
        end else begin
            state_r                           <= state_next_s;
            sdramstartstop_beginbursttransfer <= (state_next_s == ISSUE);
            donesignal_export                 <= (state_next_s == DONE);
        end
    end

    // Burst and saturating cycle counters; both hold their value once the run leaves ISSUE/WAIT.
    always_ff @(posedge sys_ref_clk_clk or negedge sys_ref_reset_reset_n) begin
        if (!sys_ref_reset_reset_n) begin
            burst_count <= 16'd0;
            cycle_count <= {CNT_W{1'b0}};
        end else if (arm_s) begin
            burst_count <= 16'd0;
            cycle_count <= {CNT_W{1'b0}};
        end else begin
            if (count_resp_s) begin
                burst_count <= burst_inc_s;
            end
            if (((state_r == ISSUE) || (state_r == WAIT)) && (cycle_count != CNT_MAX)) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
        end
    end

`ifdef SDRAM_BURST_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_r;

    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // Per-burst response timer, restarted by every burst-begin, and the sticky timeout flag.
    always_ff @(posedge sys_ref_clk_clk or negedge sys_ref_reset_reset_n) begin
        if (!sys_ref_reset_reset_n) begin
            tmo_cnt_r    <= 16'd0;
            timeout_flag <= 1'b0;
        end else if (arm_s) begin
            tmo_cnt_r    <= 16'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (state_r == ISSUE) begin
                tmo_cnt_r <= 16'd0;
            end else if (state_r == WAIT) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end
            if (tmo_fire_s) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit_s    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// Directed bench for sdram_burst_sequencer with NUM_BURSTS=4, TIMEOUT_CYCLES=100.
`timescale 1ns/1ps
module tb_sdram_burst_sequencer;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic [3:0]  keys   = 4'hF;
    logic        resp_n = 1'b1;
    logic        begin_o;
    logic        done;
    logic        tmo;
    logic [15:0] bcnt;
    logic [31:0] ccnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdram_burst_sequencer #(
        .NUM_BURSTS    (4),
        .TIMEOUT_CYCLES(100),
        .CNT_W         (32)
    ) dut (
        .sys_ref_clk_clk                    (clk),
        .sys_ref_reset_reset_n              (rst_n),
        .startsignal_export                 (start),
        .pushbutton_export                  (keys),
        .sdramstartstop_writeresponsevalid_n(resp_n),
        .sdramstartstop_beginbursttransfer  (begin_o),
        .donesignal_export                  (done),
        .timeout_flag                       (tmo),
        .burst_count                        (bcnt),
        .cycle_count                        (ccnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_begin(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (begin_o === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // From a begin cycle: response driven in the 3rd WAIT cycle.
    task automatic normal_burst();
        tick();
        tick();
        tick();
        resp_n = 1'b0;
        tick();
        resp_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (begin_o !== 1'b0) begin n_fail++; $display("FAIL reset_begin: got %b want 0", begin_o); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", tmo); end
        n_checks++; if (bcnt !== 16'd0) begin n_fail++; $display("FAIL reset_burst_count: got %0d want 0", bcnt); end
        n_checks++; if (ccnt !== 32'd0) begin n_fail++; $display("FAIL reset_cycle_count: got %0d want 0", ccnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (begin_o !== 1'b0) begin n_fail++; $display("FAIL idle_no_begin: got %b want 0", begin_o); end
    endtask

    task automatic test_nominal();
        bit found;
        start = 1'b1;
        tick();
        n_checks++; if (begin_o !== 1'b1) begin n_fail++; $display("FAIL start_latency: begin=%b want 1", begin_o); end
        n_checks++; if (ccnt !== 32'd0) begin n_fail++; $display("FAIL start_cycle_count: got %0d want 0", ccnt); end
        for (int b = 0; b < 4; b++) begin
            wait_begin(8, found);
            n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL nominal_begin_seen burst %0d: found=%b want 1", b, found); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL nominal_done_early burst %0d: got %b want 0", b, done); end
            tick();
            n_checks++; if (begin_o !== 1'b0) begin n_fail++; $display("FAIL nominal_pulse_width burst %0d: begin=%b want 0", b, begin_o); end
            tick();
            tick();
            resp_n = 1'b0;
            tick();
            resp_n = 1'b1;
            if (b < 3) begin
                n_checks++; if (begin_o !== 1'b1) begin n_fail++; $display("FAIL resp_to_begin burst %0d: begin=%b want 1", b, begin_o); end
                n_checks++; if (bcnt !== 16'(b + 1)) begin n_fail++; $display("FAIL nominal_burst_count burst %0d: got %0d want %0d", b, bcnt, b + 1); end
            end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nominal_done: got %b want 1", done); end
        n_checks++; if (bcnt !== 16'd4) begin n_fail++; $display("FAIL nominal_final_bursts: got %0d want 4", bcnt); end
        n_checks++; if (ccnt !== 32'd16) begin n_fail++; $display("FAIL nominal_cycles: got %0d want 16", ccnt); end
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL nominal_timeout: got %b want 0", tmo); end
        n_checks++; if (begin_o !== 1'b0) begin n_fail++; $display("FAIL nominal_extra_begin: got %b want 0", begin_o); end
    endtask

    task automatic test_start_hold();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done cycle %0d: got %b want 1", i, done); end
            n_checks++; if (begin_o !== 1'b0) begin n_fail++; $display("FAIL hold_begin cycle %0d: got %b want 0", i, begin_o); end
        end
        start = 1'b0;
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL hold_done_clear: got %b want 0", done); end
        n_checks++; if (bcnt !== 16'd4) begin n_fail++; $display("FAIL hold_last_bursts: got %0d want 4", bcnt); end
        n_checks++; if (ccnt !== 32'd16) begin n_fail++; $display("FAIL hold_last_cycles: got %0d want 16", ccnt); end
        start = 1'b1;
        tick();
        n_checks++; if (begin_o !== 1'b1) begin n_fail++; $display("FAIL rerun_begin: got %b want 1", begin_o); end
        n_checks++; if (bcnt !== 16'd0) begin n_fail++; $display("FAIL rerun_burst_clear: got %0d want 0", bcnt); end
        n_checks++; if (ccnt !== 32'd0) begin n_fail++; $display("FAIL rerun_cycle_clear: got %0d want 0", ccnt); end
    endtask

    task automatic test_timeout();
        normal_burst();
        n_checks++; if (begin_o !== 1'b1) begin n_fail++; $display("FAIL tmo_second_begin: got %b want 1", begin_o); end
        tick();
        repeat (99) tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL tmo_early_done: got %b want 0", done); end
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early_flag: got %b want 0", tmo); end
        tick();
        n_checks++; if (bcnt !== 16'd1) begin n_fail++; $display("FAIL tmo_bursts: got %0d want 1", bcnt); end
        n_checks++; if (ccnt !== 32'd105) begin n_fail++; $display("FAIL tmo_cycles: got %0d want 105", ccnt); end
`ifdef SDRAM_BURST_SEQ_TIMEOUT_EN
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got %b want 1", done); end
        n_checks++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", tmo); end
        start = 1'b0;
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL tmo_done_clear: got %b want 0", done); end
`else
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL notmo_done: got %b want 0", done); end
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL notmo_flag: got %b want 0", tmo); end
        keys[0] = 1'b0;
        tick();
        keys[0] = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        tick();
`endif
    endtask

    task automatic test_threshold();
        start = 1'b1;
        tick();
        n_checks++; if (begin_o !== 1'b1) begin n_fail++; $display("FAIL thr_first_begin: got %b want 1", begin_o); end
        normal_burst();
        tick();
        repeat (99) tick();
        resp_n = 1'b0;
        tick();
        resp_n = 1'b1;
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL thr_flag: got %b want 0", tmo); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL thr_done: got %b want 0", done); end
        n_checks++; if (bcnt !== 16'd2) begin n_fail++; $display("FAIL thr_bursts: got %0d want 2", bcnt); end
        n_checks++; if (begin_o !== 1'b1) begin n_fail++; $display("FAIL thr_third_begin: got %b want 1", begin_o); end
        n_checks++; if (ccnt !== 32'd105) begin n_fail++; $display("FAIL thr_cycles: got %0d want 105", ccnt); end
    endtask

    task automatic test_reset_mid_run();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (begin_o !== 1'b0) begin n_fail++; $display("FAIL midrst_begin: got %b want 0", begin_o); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout: got %b want 0", tmo); end
        n_checks++; if (bcnt !== 16'd0) begin n_fail++; $display("FAIL midrst_bursts: got %0d want 0", bcnt); end
        n_checks++; if (ccnt !== 32'd0) begin n_fail++; $display("FAIL midrst_cycles: got %0d want 0", ccnt); end
        start  = 1'b0;
        resp_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        resp_n = 1'b1;
        n_checks++; if (bcnt !== 16'd0) begin n_fail++; $display("FAIL idle_stray_resp: got %0d want 0", bcnt); end
        n_checks++; if (begin_o !== 1'b0) begin n_fail++; $display("FAIL idle_stray_begin: got %b want 0", begin_o); end
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        n_checks++; if (begin_o !== 1'b1) begin n_fail++; $display("FAIL abort_first_begin: got %b want 1", begin_o); end
        normal_burst();
        n_checks++; if (begin_o !== 1'b1) begin n_fail++; $display("FAIL abort_second_begin: got %b want 1", begin_o); end
        tick();
        keys[0] = 1'b0;
        tick();
        keys[0] = 1'b1;
        n_checks++; if (ccnt !== 32'd6) begin n_fail++; $display("FAIL abort_cycles_e0: got %0d want 6", ccnt); end
        tick();
        n_checks++; if (ccnt !== 32'd7) begin n_fail++; $display("FAIL abort_cycles_e1: got %0d want 7", ccnt); end
        tick();
        n_checks++; if (ccnt !== 32'd8) begin n_fail++; $display("FAIL abort_cycles_e2: got %0d want 8", ccnt); end
        resp_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            resp_n = 1'b1;
            n_checks++; if (begin_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_begin cycle %0d: got %b want 0", i, begin_o); end
            n_checks++; if (ccnt !== 32'd8) begin n_fail++; $display("FAIL abort_frozen cycle %0d: got %0d want 8", i, ccnt); end
        end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
        n_checks++; if (bcnt !== 16'd1) begin n_fail++; $display("FAIL abort_bursts: got %0d want 1", bcnt); end
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL abort_timeout: got %b want 0", tmo); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_start_hold();
        test_timeout();
        test_threshold();
        test_reset_mid_run();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
